rx_uart_ex: RTL and testbench
=============================

# rx_uart_ex

Parametrised UART receiver that replaces the fixed 8N1 receiver in new designs. It supports configurable data width, parity and stop bits, and a synchronised input with 3-sample majority voting. Received frames go into a first-word-fall-through FIFO, and each entry carries its own error flags. The block sits between the board RX pin and any host/command parser that drains bytes with a simple read strobe.

## Interface
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- FIFO_DEPTH, 16: number of FIFO entries; must be a power of 2 and ≥2.
- SYNC_STAGES, 2: number of flops in the rx_pin synchroniser; ≥2.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- baud_div  in  16  clocks per bit (F_CLK/BAUD). Must be ≥4. Changed only while `busy`=0.
- parity_mode  in  2  parity selection: 0 = none, 1 = even, 2 = odd, 3 = none.
- stop_bits  in  1  stop bits per frame: 0 = one, 1 = two.
- rx_pin  in  1  asynchronous serial input; idle level is high.
- rd_en  in  1  pops the FIFO head when `rd_valid`=1; ignored when the FIFO is empty.
- rd_valid  out  1  FIFO is non-empty.
- rd_data  out  DATA_BITS  data of the FIFO head, LSB received first.
- rd_perr  out  1  parity error flag of the FIFO head.
- rd_ferr  out  1  framing error flag of the FIFO head (a stop bit was sampled 0).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- overrun  out  1  sticky flag: a frame was dropped because the FIFO was full.
- clr_ovr  in  1  clears `overrun`.
- busy  out  1  receiver FSM is not in IDLE.

## Operation
- **Synchroniser:** rx_pin passes through SYNC_STAGES flops, reset to 1. `rxs` is the synchronised value.
- **Bit timing:** counter `cnt` runs 0..baud_div-1 within each bit cell; h = baud_div>>1.
  - `rxs` is sampled at cnt = h-1, h and h+1.
  - The bit value is the majority of the 3 samples, decided at cnt = h+1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on the first cycle `rxs`=0. `cnt` is cleared and the shift register is zeroed.
  - START: majority 1 → IDLE (false start, nothing pushed). Majority 0 → wait until cnt = baud_div-1, then go to DATA.
  - DATA: DATA_BITS cells, shifted in LSB-first. Then go to PARITY if parity is enabled, else to STOP.
  - PARITY: one cell. perr = (received parity ≠ expected parity). Even mode: the data bits XOR the parity bit must equal 0. Odd mode: it must equal 1.
  - STOP: one or two cells. ferr is set if any stop cell decides 0.
    - At the decision of the final stop cell, the FSM pushes {ferr, perr, data} and returns to IDLE in the same cycle.
    - It does not wait for the end of that cell, so a start edge in the second half of the stop bit is caught.
- **Push conditions:** frames with perr or ferr are still pushed. With parity disabled, perr=0.
- **FIFO:** first-word-fall-through. `rd_data`, `rd_perr` and `rd_ferr` are valid whenever `rd_valid`=1.
  - Push when full, without a simultaneous pop: the frame is dropped and `overrun` is set. FIFO contents are unchanged.
  - Push and pop in the same cycle: always accepted, including when full. Count is unchanged and no overrun occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- **`overrun`:** clr_ovr clears it. If clr_ovr and a new overrun occur in the same cycle, the set wins.
- **Configuration:** parity_mode and stop_bits are sampled at IDLE → START and held for the whole frame.

## Timing
- **Reset values:** rd_valid=0, rd_data=0, rd_perr=0, rd_ferr=0, fifo_count=0, overrun=0, busy=0. FSM is in IDLE and the synchroniser is all 1s.
- **Reset mid-frame:** the frame is aborted, nothing is pushed, and the FIFO is emptied.
- **Input latency:** rx_pin to `rxs` is SYNC_STAGES cycles.
- **Frame length:** N = 1 + DATA_BITS + P + S cells, where P = 1 if parity is enabled (else 0) and S = 1 or 2 stop bits.
  - Let T0 be the cycle `rxs` first reads 0.
  - The push occurs at T0 + (N-1)·baud_div + h + 1.
  - rd_valid and fifo_count update on the following edge.
- **Pop timing:** rd_en=1 with rd_valid=1 pops on that edge. The next head (or rd_valid=0) is visible the next cycle.
- **Throughput:** back-to-back frames with zero idle time are received without loss while the FIFO is not full.

## Test plan
- **8N1 basic:** baud_div=16, 8N1, send 0xA5 then 0x3C back-to-back → two entries, data 0xA5 then 0x3C, perr=ferr=0, fifo_count=2, push cycles match the Timing formula.
- **Parity and stop errors:** even parity, 2 stop bits, send 0x07 with parity bit 0, then 0x55 with a second stop bit of 0 → entry 1 has perr=1, ferr=0; entry 2 has perr=0, ferr=1.
- **Noise rejection:** rx_pin low for 3 cycles only → no push, busy returns to 0. A 1-cycle high glitch at cnt=h inside data bit 0 of byte 0x00 → 0x00 received.
- **Overrun:** FIFO_DEPTH=16, send 17 frames with no reads → fifo_count=16, overrun=1, head is the first byte. Then pop and push in the same cycle while full → accepted, no change to overrun. clr_ovr → overrun=0.
- **Width and reset:** DATA_BITS=5, odd parity, send 0x1F → rd_data=0x1F, perr=0. Assert rst_n=0 mid-frame, then release → FIFO empty and the next frame is received correctly.

Source files
------------

// File: rtl/rx_uart_ex.sv
// rx_uart_ex: configurable UART receiver with 3-sample majority voting
// and a first-word-fall-through FIFO carrying per-frame error flags.
module rx_uart_ex #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [15:0]                 baud_div,
    input  logic [1:0]                  parity_mode,
    input  logic                        stop_bits,
    input  logic                        rx_pin,
    input  logic                        rd_en,
    output logic                        rd_valid,
    output logic [DATA_BITS-1:0]        rd_data,
    output logic                        rd_perr,
    output logic                        rd_ferr,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overrun,
    input  logic                        clr_ovr,
    output logic                        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t                 r_state, w_state_n;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [15:0]            r_cnt, w_cnt_n;
    logic [BW-1:0]          r_bit, w_bit_n;
    logic [DATA_BITS-1:0]   r_shift, w_shift_n;
    logic                   r_s0, r_s1;
    logic                   r_perr, w_perr_n;
    logic                   r_ferr, w_ferr_n;
    logic                   r_stop_idx, w_stop_idx_n;
    logic                   r_par_en, r_par_odd, r_two;
    logic                   w_cfg_ld, w_push;
    logic                   w_rxs, w_maj, w_dec, w_last;
    logic [15:0]            w_h;

    assign w_rxs  = r_sync[SYNC_STAGES-1];
    assign w_h    = {1'b0, baud_div[15:1]};
    assign w_dec  = (r_cnt == w_h + 16'd1);
    assign w_last = (r_cnt == baud_div - 16'd1);
    assign w_maj  = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync     <= '1;
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_stop_idx <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_two      <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], rx_pin};
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_bit      <= w_bit_n;
            r_shift    <= w_shift_n;
            r_perr     <= w_perr_n;
            r_ferr     <= w_ferr_n;
            r_stop_idx <= w_stop_idx_n;
            if (r_cnt == w_h - 16'd1) r_s0 <= w_rxs;
            if (r_cnt == w_h)         r_s1 <= w_rxs;
            if (w_cfg_ld) begin
                r_par_en  <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
                r_par_odd <= (parity_mode == 2'd2);
                r_two     <= stop_bits;
            end
        end
    end

    // The IDLE cycle that sees the start edge counts as cnt=0 of the start cell.
    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = w_last ? 16'd0 : r_cnt + 16'd1;
        w_bit_n      = r_bit;
        w_shift_n    = r_shift;
        w_perr_n     = r_perr;
        w_ferr_n     = r_ferr;
        w_stop_idx_n = r_stop_idx;
        w_cfg_ld     = 1'b0;
        w_push       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (!w_rxs) begin
                    w_state_n    = S_START;
                    w_cnt_n      = 16'd1;
                    w_bit_n      = '0;
                    w_shift_n    = '0;
                    w_perr_n     = 1'b0;
                    w_ferr_n     = 1'b0;
                    w_stop_idx_n = 1'b0;
                    w_cfg_ld     = 1'b1;
                end
            end
            S_START: begin
                if (w_dec && w_maj) w_state_n = S_IDLE;
                else if (w_last)    w_state_n = S_DATA;
            end
            S_DATA: begin
                if (w_dec) w_shift_n = {w_maj, r_shift[DATA_BITS-1:1]};
                if (w_last) begin
                    if (r_bit == BW'(DATA_BITS - 1)) begin
                        w_bit_n   = '0;
                        w_state_n = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_n = r_bit + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_dec) w_perr_n = ((^r_shift) ^ w_maj) != r_par_odd;
                if (w_last) w_state_n = S_STOP;
            end
            S_STOP: begin
                if (w_dec) begin
                    if (!w_maj) w_ferr_n = 1'b1;
                    if (r_stop_idx == r_two) begin
                        w_push    = 1'b1;
                        w_state_n = S_IDLE;
                    end
                end
                if (w_last && (w_state_n == S_STOP)) w_stop_idx_n = 1'b1;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count;
    logic          r_ovr;
    logic          w_full, w_pop, w_wr, w_ovr_set;
    logic [EW-1:0] w_head;

    assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop     = rd_en && (r_count != '0);
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;
    assign w_head    = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= {w_ferr_n, r_perr, r_shift};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_wr)  r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A fresh drop outranks a simultaneous clear.
            if (w_ovr_set)    r_ovr <= 1'b1;
            else if (clr_ovr) r_ovr <= 1'b0;
        end
    end

    assign rd_valid   = (r_count != '0);
    assign rd_data    = rd_valid ? w_head[DATA_BITS-1:0] : '0;
    assign rd_perr    = rd_valid & w_head[DATA_BITS];
    assign rd_ferr    = rd_valid & w_head[DATA_BITS+1];
    assign fifo_count = r_count;
    assign overrun    = r_ovr;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_rx_uart_ex.sv
// tb_rx_uart_ex: vector table, directed corner cases and randomized
// frames checked against a frame-level reference model.
module tb_rx_uart_ex;
    localparam int SS = 2;

    typedef bit bitq_t[$];
    typedef struct {
        logic [7:0] data;
        logic [1:0] pmode;
        bit         two;
        bit         par;
        bit         st1;
        bit         st2;
        bit         eperr;
        bit         eferr;
    } vec_t;
    typedef struct {
        logic [7:0] data;
        bit         perr;
        bit         ferr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rx_pin, rd_en, clr_ovr, stop_bits;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        rd_valid, rd_perr, rd_ferr, overrun, busy;
    logic [7:0]  rd_data;
    logic [4:0]  fifo_count;

    logic        rx5, rd_en5;
    logic        rd_valid5, rd_perr5, rd_ferr5, overrun5, busy5;
    logic [4:0]  rd_data5;
    logic [2:0]  fifo_count5;

    rx_uart_ex #(.DATA_BITS(8), .FIFO_DEPTH(16), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div),
        .parity_mode(parity_mode), .stop_bits(stop_bits),
        .rx_pin(rx_pin), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr),
        .fifo_count(fifo_count), .overrun(overrun),
        .clr_ovr(clr_ovr), .busy(busy)
    );

    rx_uart_ex #(.DATA_BITS(5), .FIFO_DEPTH(4), .SYNC_STAGES(SS)) dut5 (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div),
        .parity_mode(parity_mode), .stop_bits(stop_bits),
        .rx_pin(rx5), .rd_en(rd_en5), .rd_valid(rd_valid5),
        .rd_data(rd_data5), .rd_perr(rd_perr5), .rd_ferr(rd_ferr5),
        .fifo_count(fifo_count5), .overrun(overrun5),
        .clr_ovr(clr_ovr), .busy(busy5)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int push_cyc[$];
    logic [4:0] prev_cnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (fifo_count > prev_cnt) push_cyc.push_back(cyc);
        prev_cnt = fifo_count;
    end

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic bitq_t mk_frame(int nb, logic [8:0] d, logic [1:0] pm,
                                       bit two, bit par, bit st1, bit st2);
        bitq_t q;
        q.push_back(1'b0);
        for (int i = 0; i < nb; i++) q.push_back(d[i]);
        if (pm == 2'd1 || pm == 2'd2) q.push_back(par);
        q.push_back(st1);
        if (two) q.push_back(st2);
        return q;
    endfunction

    // Parity error by the rule: data ones plus parity bit, even or odd.
    function automatic bit ref_perr(int nb, logic [8:0] d, logic [1:0] pm, bit par);
        int ones;
        ones = int'(par);
        for (int i = 0; i < nb; i++) ones += int'(d[i]);
        if (pm == 2'd1) return (ones % 2) != 0;
        if (pm == 2'd2) return (ones % 2) != 1;
        return 1'b0;
    endfunction

    task automatic drive(input bitq_t bits, input bit sel, input int gcell, input int goff);
        logic v;
        for (int i = 0; i < bits.size(); i++) begin
            for (int c = 0; c < int'(baud_div); c++) begin
                v = bits[i];
                if (i == gcell && c == goff) v = ~v;
                if (sel) rx5 = v;
                else     rx_pin = v;
                @(posedge clk); #1;
            end
        end
        if (sel) rx5 = 1'b1;
        else     rx_pin = 1'b1;
    endtask

    task automatic send(input logic [8:0] d, input logic [1:0] pm, input bit two,
                        input bit par, input bit st1, input bit st2,
                        input bit sel, input int gcell, input int goff);
        parity_mode = pm;
        stop_bits   = two;
        drive(mk_frame(sel ? 5 : 8, d, pm, two, par, st1, st2), sel, gcell, goff);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || busy5) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", n < 5000, 1);
        repeat (2 * int'(baud_div)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pop_check(string nm, logic [7:0] d, bit pe, bit fe);
        check({nm, "_valid"}, rd_valid, 1);
        check({nm, "_entry"}, {rd_ferr, rd_perr, rd_data}, {fe, pe, d});
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    vec_t tbl[8];
    exp_t exp_q[$];

    initial begin
        int st, nfr, gap;
        logic [7:0] d;
        logic [1:0] pm;
        bit two, par, s1, s2, pe;

        tbl[0] = '{8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h07, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{8'h55, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h01, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{8'hC3, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        rx_pin = 1'b1; rx5 = 1'b1; rd_en = 1'b0; rd_en5 = 1'b0;
        clr_ovr = 1'b0; baud_div = 16'd16; parity_mode = 2'd0;
        stop_bits = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_flags", {rd_perr, rd_ferr}, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);

        // 8N1 back-to-back with push timing
        repeat (4) begin @(posedge clk); #1; end
        push_cyc.delete();
        st = cyc;
        send(9'h0A5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0);
        send(9'h03C, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0);
        wait_idle();
        check("basic_count", fifo_count, 2);
        check("basic_npush", push_cyc.size(), 2);
        check("basic_t0", push_cyc.size() > 0 ? push_cyc[0] - st : -1,
              SS + 9 * 16 + 8 + 2);
        check("basic_t1", push_cyc.size() > 1 ? push_cyc[1] - st : -1,
              160 + SS + 9 * 16 + 8 + 2);
        pop_check("basic_a5", 8'hA5, 1'b0, 1'b0);
        pop_check("basic_3c", 8'h3C, 1'b0, 1'b0);
        check("basic_empty", rd_valid, 0);

        for (int i = 0; i < 8; i++) begin
            send({1'b0, tbl[i].data}, tbl[i].pmode, tbl[i].two, tbl[i].par,
                 tbl[i].st1, tbl[i].st2, 1'b0, -1, 0);
            wait_idle();
            check($sformatf("vec%0d_count", i), fifo_count, 1);
            pop_check($sformatf("vec%0d", i), tbl[i].data, tbl[i].eperr, tbl[i].eferr);
        end

        // short low pulse is a false start
        rx_pin = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rx_pin = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("noise_busy", busy, 1);
        repeat (30) begin @(posedge clk); #1; end
        check("noise_idle", busy, 0);
        check("noise_count", fifo_count, 0);

        send(9'h000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 8);
        wait_idle();
        pop_check("glitch", 8'h00, 1'b0, 1'b0);

        // overrun: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++)
            send(9'(8'h10 + i), 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0);
        wait_idle();
        check("ovr_count", fifo_count, 16);
        check("ovr_flag", overrun, 1);
        check("ovr_head", rd_data, 8'h10);
        clr_ovr = 1'b1;
        @(posedge clk); #1;
        clr_ovr = 1'b0;
        check("ovr_clr", overrun, 0);
        fork
            send(9'h077, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0);
            begin
                repeat (SS + 9 * 16 + 8 + 1) @(posedge clk);
                #1 rd_en = 1'b1;
                @(posedge clk);
                #1 rd_en = 1'b0;
            end
        join
        wait_idle();
        check("full_pp_count", fifo_count, 16);
        check("full_pp_ovr", overrun, 0);
        for (int i = 1; i < 16; i++)
            pop_check($sformatf("drain%0d", i), 8'(8'h10 + i), 1'b0, 1'b0);
        pop_check("drain_new", 8'h77, 1'b0, 1'b0);
        check("drain_empty", fifo_count, 0);

        // 5-bit data, odd parity, then reset mid-frame
        send(9'h01F, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0);
        wait_idle();
        check("w5_count", fifo_count5, 1);
        check("w5_entry", {rd_ferr5, rd_perr5, rd_data5}, {2'b00, 5'h1F});
        rx5 = 1'b0;
        repeat (48) begin @(posedge clk); #1; end
        check("w5_busy_mid", busy5, 1);
        rst_n = 1'b0;
        rx5 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        check("rst5_count", fifo_count5, 0);
        check("rst5_valid", rd_valid5, 0);
        check("rst5_data", rd_data5, 0);
        check("rst5_busy", busy5, 0);
        check("rst5_ovr", overrun5, 0);
        check("rst8_count", fifo_count, 0);
        send(9'h00A, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0);
        wait_idle();
        check("w5b_count", fifo_count5, 1);
        check("w5b_entry", {rd_ferr5, rd_perr5, rd_data5}, {2'b00, 5'h0A});

        // randomized batches against the frame-level model
        for (int b = 0; b < 6; b++) begin
            baud_div = 16'($urandom_range(4, 24));
            repeat (4) begin @(posedge clk); #1; end
            nfr = $urandom_range(1, 10);
            for (int k = 0; k < nfr; k++) begin
                d   = 8'($urandom);
                pm  = 2'($urandom);
                two = 1'($urandom);
                par = ref_perr(8, {1'b0, d}, pm, 1'b0);
                if ($urandom_range(0, 3) == 0) par = ~par;
                s1  = ($urandom_range(0, 7) != 0);
                s2  = ($urandom_range(0, 7) != 0);
                pe  = ref_perr(8, {1'b0, d}, pm, par);
                exp_q.push_back('{d, pe, !s1 || (two && !s2)});
                send({1'b0, d}, pm, two, par, s1, s2, 1'b0, -1, 0);
                gap = ((two ? s2 : s1) == 1'b0) ? 3 * int'(baud_div)
                                               : $urandom_range(0, 2);
                repeat (gap) begin @(posedge clk); #1; end
            end
            wait_idle();
            check($sformatf("rnd%0d_count", b), fifo_count, exp_q.size());
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                pop_check($sformatf("rnd%0d", b), e.data, e.perr, e.ferr);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
